// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting NUM_REQ writers time-sliced bursts into one shared register.
// Optional contention counter enabled by defining CONFLICT_CNT_EN.
module shared_reg_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic [DATA_W-1:0]         out,
  output logic                      out_valid
`ifdef CONFLICT_CNT_EN
  ,
  output logic [15:0]               conflict_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [PTR_W-1:0]    winner;
  logic [DATA_W-1:0]   owner_wdata;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + PTR_W'(1);
  endfunction

  // Walk the ring starting at ptr; the first set request wins.
  function automatic logic [PTR_W-1:0] find_winner(input logic [NUM_REQ-1:0] r,
                                                   input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;
    idx   = ptr;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return win;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  assign winner      = find_winner(req, rr_ptr_q);
  assign owner_wdata = wdata[int'(owner_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = gnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d       = onehot(winner);
          owner_d     = winner;
          burst_cnt_d = '0;
          state_d     = OWN;
        end
      end
      OWN: begin
        if (req[owner_q]) begin
          out_d       = owner_wdata;
          out_valid_d = 1'b1;
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        // Release on the last allowed write or as soon as the owner drops its request.
        if (!req[owner_q] || (burst_cnt_d == BURST_LAST)) begin
          state_d  = GAP;
          gnt_d    = '0;
          rr_ptr_d = next_idx(owner_q);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  function automatic logic multi_req(input logic [NUM_REQ-1:0] r);
    return |(r & (r - NUM_REQ'(1)));
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Contention is only meaningful while arbitration is actually happening.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((state_q == IDLE) && multi_req(req)) conflict_cnt_d = sat_inc16(conflict_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_q <= '0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
